stochastic_mean_bank: RTL and testbench

Multi-channel, parametrised successor to the single-channel stochastic mean counter. For each of N_CH stochastic bit-streams it counts ones over a programmable window of LEN enabled cycles. At window end it latches either the unipolar count or the bipolar value (2·count − LEN) and presents all channels together behind a valid/ready output handshake, with overrun detection. It sits between the stochastic neuron array and the binary readout/weight-update logic.

---
 rtl/stochastic_mean_bank.sv | 125 ++++++++++++
 tb/tb_stochastic_mean_bank.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stochastic_mean_bank.sv
// Per-channel ones counter over a window of LEN enabled cycles; publishes unipolar or bipolar results.
// Latency: results are registered at the edge that samples the last enabled bit of the window.
// Backpressure: none toward IN; an unaccepted result is overwritten and OVERRUN is set (sticky).
module stochastic_mean_bank #(
   parameter int N_CH    = 4,
   parameter int N_COUNT = 8
) (
   input  logic                          CLK,
   input  logic                          RESETn,
   input  logic [N_CH-1:0]               IN,
   input  logic                          ENABLE,
   input  logic                          GO,
   input  logic [N_COUNT-1:0]            LEN,
   input  logic                          MODE,
   input  logic                          INIT,
   input  logic [N_COUNT-1:0]            START,
   output logic [N_CH*(N_COUNT+1)-1:0]   OUT,
   output logic                          OUT_VALID,
   input  logic                          OUT_READY,
   output logic                          OVERRUN,
   output logic                          BUSY
);

   localparam int W = N_COUNT + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state;
   logic [N_COUNT-1:0]   sum     [N_CH];
   logic [N_COUNT-1:0]   sum_inc [N_CH];
   logic [N_COUNT-1:0]   cnt;
   logic [N_COUNT-1:0]   len_q;
   logic                 mode_q;
   logic                 last;

   // Bipolar value wraps modulo 2^W; the true result always lies in [-len, +len], so it is exact.
   function automatic logic [W-1:0] result(input logic [N_COUNT-1:0] s,
                                           input logic               m,
                                           input logic [N_COUNT-1:0] l);
      return m ? ({s, 1'b0} - {1'b0, l}) : {1'b0, s};
   endfunction

   // Sum including the current sample; never exceeds len_q, so no carry out is lost.
   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         sum_inc[c] = sum[c] + N_COUNT'(IN[c]);
      end
   end

   assign last = ENABLE && (cnt == len_q - N_COUNT'(1));

   // Window FSM, accumulators, result register and output handshake.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state     <= IDLE;
         BUSY      <= 1'b0;
         OUT       <= '0;
         OUT_VALID <= 1'b0;
         OVERRUN   <= 1'b0;
         cnt       <= '0;
         len_q     <= '0;
         mode_q    <= 1'b0;
         for (int c = 0; c < N_CH; c++) sum[c] <= '0;
      end else if (INIT) begin
         state     <= IDLE;
         BUSY      <= 1'b0;
         cnt       <= '0;
         OUT_VALID <= 1'b0;
         OVERRUN   <= 1'b0;
         for (int c = 0; c < N_CH; c++) begin
            OUT[c*W +: W] <= {1'b0, START};
            sum[c]        <= '0;
         end
      end else begin
         // Acceptance without a completion retires the current result.
         if (OUT_VALID && OUT_READY) OUT_VALID <= 1'b0;

         case (state)
            IDLE: begin
               if (GO && LEN != '0) begin
                  state  <= RUN;
                  BUSY   <= 1'b1;
                  len_q  <= LEN;
                  mode_q <= MODE;
                  cnt    <= '0;
                  for (int c = 0; c < N_CH; c++) sum[c] <= '0;
               end
            end
            RUN: begin
               if (last) begin
                  // A completing sample publishes even if GO drops on the same cycle.
                  for (int c = 0; c < N_CH; c++) begin
                     OUT[c*W +: W] <= result(sum_inc[c], mode_q, len_q);
                     sum[c]        <= '0;
                  end
                  cnt       <= '0;
                  OUT_VALID <= 1'b1;
                  if (OUT_VALID && !OUT_READY) OVERRUN <= 1'b1;
                  // Window parameters only change between windows.
                  len_q  <= LEN;
                  mode_q <= MODE;
                  if (!GO || LEN == '0) begin
                     state <= IDLE;
                     BUSY  <= 1'b0;
                  end
               end else if (!GO) begin
                  // Abort: partial window is dropped, published result untouched.
                  state <= IDLE;
                  BUSY  <= 1'b0;
                  cnt   <= '0;
                  for (int c = 0; c < N_CH; c++) sum[c] <= '0;
               end else if (ENABLE) begin
                  cnt <= cnt + N_COUNT'(1);
                  for (int c = 0; c < N_CH; c++) sum[c] <= sum_inc[c];
               end
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stochastic_mean_bank.sv
// Directed bench for stochastic_mean_bank: window counting, bipolar/gating, handshake,
// INIT/abort, LEN boundaries and asynchronous reset, with hand-computed expectations.
module tb_stochastic_mean_bank;

   localparam int N_CH    = 4;
   localparam int N_COUNT = 8;
   localparam int W       = N_COUNT + 1;

   logic                 clk;
   logic                 rst_n;
   logic [N_CH-1:0]      in_bits;
   logic                 enable;
   logic                 go;
   logic [N_COUNT-1:0]   len;
   logic                 mode;
   logic                 init;
   logic [N_COUNT-1:0]   start;
   logic [N_CH*W-1:0]    out_dat;
   logic                 out_vld;
   logic                 out_rdy;
   logic                 overrun;
   logic                 busy;

   int checks = 0;
   int errors = 0;

   stochastic_mean_bank #(.N_CH(N_CH), .N_COUNT(N_COUNT)) dut (
      .CLK       (clk),
      .RESETn    (rst_n),
      .IN        (in_bits),
      .ENABLE    (enable),
      .GO        (go),
      .LEN       (len),
      .MODE      (mode),
      .INIT      (init),
      .START     (start),
      .OUT       (out_dat),
      .OUT_VALID (out_vld),
      .OUT_READY (out_rdy),
      .OVERRUN   (overrun),
      .BUSY      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] ch(input int c);
      return out_dat[c*W +: W];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_bits = '0; enable = 1'b1; go = 1'b0; len = '0; mode = 1'b0;
      init = 1'b0; start = '0; out_rdy = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
      chk("reset_out",     64'(out_dat), 64'h0);
      chk("reset_valid",   64'(out_vld), 64'h0);
      chk("reset_overrun", 64'(overrun), 64'h0);
      chk("reset_busy",    64'(busy),    64'h0);

      // ---- unipolar window, LEN=8
      go = 1'b1; len = 8'd8; mode = 1'b0;
      step();
      chk("uni_busy", 64'(busy), 64'h1);
      for (int i = 0; i < 8; i++) begin
         in_bits[0] = 1'b1;
         in_bits[1] = 1'b0;
         in_bits[2] = (i % 2 == 0);
         in_bits[3] = (i < 3);
         step();
         if (i == 6) chk("uni_valid_early", 64'(out_vld), 64'h0);
      end
      chk("uni_valid", 64'(out_vld), 64'h1);
      chk("uni_ch0",   64'(ch(0)),   64'd8);
      chk("uni_ch1",   64'(ch(1)),   64'd0);
      chk("uni_ch2",   64'(ch(2)),   64'd4);
      chk("uni_ch3",   64'(ch(3)),   64'd3);
      go = 1'b0; out_rdy = 1'b1;
      step();
      chk("uni_idle_busy",  64'(busy),    64'h0);
      chk("uni_consumed",   64'(out_vld), 64'h0);
      chk("uni_out_stable", 64'(ch(0)),   64'd8);

      // ---- bipolar with ENABLE gating, LEN=4
      out_rdy = 1'b0; go = 1'b1; len = 8'd4; mode = 1'b1; in_bits = 4'b0001; enable = 1'b1;
      step();
      step(); step();
      enable = 1'b0;
      step(); step(); step();
      chk("bip_gated_valid", 64'(out_vld), 64'h0);
      enable = 1'b1;
      step();
      chk("bip_valid_early", 64'(out_vld), 64'h0);
      step();
      chk("bip_valid", 64'(out_vld), 64'h1);
      chk("bip_ch0",   64'(ch(0)),   64'h004);
      chk("bip_ch1",   64'(ch(1)),   64'h1FC);
      go = 1'b0; out_rdy = 1'b1;
      step();
      chk("bip_consumed", 64'(out_vld), 64'h0);

      // ---- handshake: same-edge accept, then overrun, LEN=2
      go = 1'b1; len = 8'd2; mode = 1'b0; in_bits = 4'b1111; out_rdy = 1'b0;
      step();
      step(); step();
      chk("hs_w1_valid",   64'(out_vld), 64'h1);
      chk("hs_w1_ch0",     64'(ch(0)),   64'd2);
      chk("hs_w1_overrun", 64'(overrun), 64'h0);
      in_bits = 4'b0001;
      step();
      chk("hs_hold_valid", 64'(out_vld), 64'h1);
      out_rdy = 1'b1;
      step();
      chk("hs_w2_valid",   64'(out_vld), 64'h1);
      chk("hs_w2_ch0",     64'(ch(0)),   64'd2);
      chk("hs_w2_ch1",     64'(ch(1)),   64'd0);
      chk("hs_w2_overrun", 64'(overrun), 64'h0);
      out_rdy = 1'b0; in_bits = 4'b0011;
      step(); step();
      chk("hs_w3_overrun", 64'(overrun), 64'h1);
      chk("hs_w3_ch1",     64'(ch(1)),   64'd2);
      chk("hs_w3_ch2",     64'(ch(2)),   64'd0);
      go = 1'b0; out_rdy = 1'b1;
      step();
      chk("hs_consumed",      64'(out_vld), 64'h0);
      chk("hs_overrun_stick", 64'(overrun), 64'h1);

      // ---- INIT mid-window
      go = 1'b1; len = 8'd8; in_bits = 4'b1111;
      step(); step(); step();
      init = 1'b1; start = 8'h55;
      step();
      init = 1'b0; go = 1'b0;
      chk("init_ch0",     64'(ch(0)),   64'h055);
      chk("init_ch3",     64'(ch(3)),   64'h055);
      chk("init_valid",   64'(out_vld), 64'h0);
      chk("init_overrun", 64'(overrun), 64'h0);
      chk("init_busy",    64'(busy),    64'h0);

      // ---- abort mid-window
      go = 1'b1; len = 8'd4;
      step(); step(); step();
      go = 1'b0;
      step();
      chk("abort_busy",  64'(busy),    64'h0);
      chk("abort_valid", 64'(out_vld), 64'h0);
      step();
      chk("abort_ch2",   64'(ch(2)),   64'h055);

      // ---- LEN=0 never starts
      go = 1'b1; len = 8'd0;
      step(); step();
      chk("len0_busy", 64'(busy), 64'h0);

      // ---- LEN=255 unipolar then bipolar
      len = 8'd255; mode = 1'b0; in_bits = 4'b1101; out_rdy = 1'b1;
      step();
      repeat (254) step();
      chk("len255_valid_early", 64'(out_vld), 64'h0);
      mode = 1'b1;
      step();
      chk("len255_uni_valid", 64'(out_vld), 64'h1);
      chk("len255_uni_ch0",   64'(ch(0)),   64'h0FF);
      chk("len255_uni_ch1",   64'(ch(1)),   64'h000);
      repeat (254) step();
      chk("len255_bip_early", 64'(out_vld), 64'h0);
      step();
      chk("len255_bip_valid", 64'(out_vld), 64'h1);
      chk("len255_bip_ch0",   64'(ch(0)),   64'h0FF);
      chk("len255_bip_ch1",   64'(ch(1)),   64'h101);
      go = 1'b0;
      step();

      // ---- LEN change mid-window applies to the next window only
      go = 1'b1; len = 8'd4; mode = 1'b0; in_bits = 4'b1111;
      step();
      step();
      len = 8'd2;
      step(); step();
      chk("lenchg_not_early", 64'(out_vld), 64'h0);
      step();
      chk("lenchg_w1_valid", 64'(out_vld), 64'h1);
      chk("lenchg_w1_ch0",   64'(ch(0)),   64'd4);
      step();
      chk("lenchg_w2_hold",  64'(ch(0)),   64'd4);
      step();
      chk("lenchg_w2_valid", 64'(out_vld), 64'h1);
      chk("lenchg_w2_ch0",   64'(ch(0)),   64'd2);
      go = 1'b0;
      step();

      // ---- asynchronous reset between edges, mid-window
      go = 1'b1; len = 8'd4; out_rdy = 1'b0; in_bits = 4'b1111;
      step(); step(); step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out",     64'(out_dat), 64'h0);
      chk("arst_valid",   64'(out_vld), 64'h0);
      chk("arst_busy",    64'(busy),    64'h0);
      chk("arst_overrun", 64'(overrun), 64'h0);
      step();
      rst_n = 1'b1; in_bits = 4'b0001;
      step();
      chk("arst_restart_busy", 64'(busy), 64'h1);
      repeat (3) step();
      chk("arst_restart_early", 64'(out_vld), 64'h0);
      step();
      chk("arst_restart_valid", 64'(out_vld), 64'h1);
      chk("arst_restart_ch0",   64'(ch(0)),   64'd4);
      chk("arst_restart_ch1",   64'(ch(1)),   64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
